// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared map geometry, cell codes and arbiter types
package map_pkg;

  localparam int unsigned MAPA_WIDTH_DFLT  = 40;
  localparam int unsigned MAPA_HEIGHT_DFLT = 30;
  localparam int unsigned COORD_W_DFLT     = 10;
  localparam int unsigned CELL_W_DFLT      = 4;

  // Cell codes stored in the map RAM
  localparam logic [3:0] CELL_EMPTY = 4'd0;
  localparam logic [3:0] CELL_SNAKE = 4'd1;
  localparam logic [3:0] CELL_FRUTA = 4'd2;
  localparam logic [3:0] CELL_WALL  = 4'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

  // Requester index; bit position in the request/ack vectors
  typedef enum logic [1:0] {
    REQ_SNAKE = 2'd0,
    REQ_FRUTA = 2'd1,
    REQ_OBST  = 2'd2
  } req_idx_e;

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational 3-way round-robin one-hot pick
module rr_arbiter3
  import map_pkg::*;
(
  input  logic [2:0] req_i,
  input  req_idx_e   ptr_i,
  output logic [2:0] gnt_o
);

  // Search starts at the pointer and wraps snake -> fruta -> obst
  always_comb begin
    gnt_o = 3'b000;
    case (ptr_i)
      REQ_FRUTA: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      REQ_OBST: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/map_write_arbiter.sv
// rtl/map_write_arbiter.sv - map RAM write-port owner: clear sweep plus 3-way arbitration (optional MAP_BORDER_WALL_EN)
module map_write_arbiter
  import map_pkg::*;
#(
  parameter int unsigned MAPA_WIDTH  = MAPA_WIDTH_DFLT,
  parameter int unsigned MAPA_HEIGHT = MAPA_HEIGHT_DFLT,
  parameter int unsigned COORD_W     = COORD_W_DFLT,
  parameter int unsigned CELL_W      = CELL_W_DFLT,
  parameter logic [CELL_W-1:0] EMPTY_CODE = CELL_W'(CELL_EMPTY),
  parameter logic [CELL_W-1:0] WALL_CODE  = CELL_W'(CELL_WALL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_start,
  input  logic               snake_req,
  input  logic               fruta_req,
  input  logic               obst_req,
  input  logic [COORD_W-1:0] snake_x,
  input  logic [COORD_W-1:0] fruta_x,
  input  logic [COORD_W-1:0] obst_x,
  input  logic [COORD_W-1:0] snake_y,
  input  logic [COORD_W-1:0] fruta_y,
  input  logic [COORD_W-1:0] obst_y,
  input  logic [CELL_W-1:0]  snake_data,
  input  logic [CELL_W-1:0]  fruta_data,
  input  logic [CELL_W-1:0]  obst_data,
  output logic               snake_ack,
  output logic               fruta_ack,
  output logic               obst_ack,
  output logic               state_write,
  output logic [COORD_W-1:0] state_xw,
  output logic [COORD_W-1:0] state_yw,
  output logic [CELL_W-1:0]  state_wdata,
  output logic               busy,
  output logic               clear_done
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAPA_HEIGHT - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  req_idx_e           ptr_q, ptr_d;
  logic               write_q, write_d;
  logic [COORD_W-1:0] xw_q, xw_d, yw_q, yw_d;
  logic [CELL_W-1:0]  wdata_q, wdata_d;
  logic [2:0]         ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2:0]         req_mask;
  logic [2:0]         gnt;
  logic               last_cell;
  logic [CELL_W-1:0]  clear_code;

  assign last_cell = (cx_q == X_LAST) && (cy_q == Y_LAST);

`ifdef MAP_BORDER_WALL_EN
  assign clear_code = ((cx_q == '0) || (cx_q == X_LAST) || (cy_q == '0) || (cy_q == Y_LAST))
                      ? WALL_CODE : EMPTY_CODE;
`else
  logic unused_wall;
  assign unused_wall = ^WALL_CODE;
  assign clear_code  = EMPTY_CODE;
`endif

  // A requester being acked this cycle is still holding req; mask it so the
  // stale request is not granted twice.
  assign req_mask = {obst_req, fruta_req, snake_req} & ~ack_q;

  rr_arbiter3 u_rr (
    .req_i (req_mask),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next state: sweep ends on the last cell unless a restart lands on it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (!clear_start && last_cell) state_d = ST_ARB;
      ST_ARB:   if (clear_start)               state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Next values of the registered outputs, cursor and pointer
  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    ptr_d   = ptr_q;
    write_d = 1'b0;
    xw_d    = xw_q;
    yw_d    = yw_q;
    wdata_d = wdata_q;
    ack_d   = 3'b000;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clear_start) begin
      cx_d   = '0;
      cy_d   = '0;
      busy_d = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          write_d = 1'b1;
          xw_d    = cx_q;
          yw_d    = cy_q;
          wdata_d = clear_code;
          busy_d  = 1'b1;
          if (last_cell) begin
            done_d = 1'b1;
            cx_d   = '0;
            cy_d   = '0;
          end else if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
        default: begin
          busy_d = 1'b0;
          if (gnt != 3'b000) begin
            write_d = 1'b1;
            ack_d   = gnt;
          end
          if (gnt[0]) begin
            xw_d = snake_x; yw_d = snake_y; wdata_d = snake_data; ptr_d = REQ_FRUTA;
          end else if (gnt[1]) begin
            xw_d = fruta_x; yw_d = fruta_y; wdata_d = fruta_data; ptr_d = REQ_OBST;
          end else if (gnt[2]) begin
            xw_d = obst_x;  yw_d = obst_y;  wdata_d = obst_data;  ptr_d = REQ_SNAKE;
          end
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q    <= '0;
      cy_q    <= '0;
      ptr_q   <= REQ_SNAKE;
      write_q <= 1'b0;
      xw_q    <= '0;
      yw_q    <= '0;
      wdata_q <= '0;
      ack_q   <= 3'b000;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ptr_q   <= ptr_d;
      write_q <= write_d;
      xw_q    <= xw_d;
      yw_q    <= yw_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state_write = write_q;
  assign state_xw    = xw_q;
  assign state_yw    = yw_q;
  assign state_wdata = wdata_q;
  assign snake_ack   = ack_q[0];
  assign fruta_ack   = ack_q[1];
  assign obst_ack    = ack_q[2];
  assign busy        = busy_q;
  assign clear_done  = done_q;

endmodule

// File: tb/tb_map_write_arbiter.sv
// tb/tb_map_write_arbiter.sv - scoreboard bench for map_write_arbiter
module tb_map_write_arbiter;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] d;
    logic [2:0] ack;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_start;
  logic [2:0] req;
  logic [9:0] rx [3];
  logic [9:0] ry [3];
  logic [3:0] rd [3];
  logic       snake_ack, fruta_ack, obst_ack;
  logic       state_write, busy, clear_done;
  logic [9:0] state_xw, state_yw;
  logic [3:0] state_wdata;
  wire  [2:0] ackv = {obst_ack, fruta_ack, snake_ack};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  map_write_arbiter dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .snake_req(req[0]), .fruta_req(req[1]), .obst_req(req[2]),
    .snake_x(rx[0]), .fruta_x(rx[1]), .obst_x(rx[2]),
    .snake_y(ry[0]), .fruta_y(ry[1]), .obst_y(ry[2]),
    .snake_data(rd[0]), .fruta_data(rd[1]), .obst_data(rd[2]),
    .snake_ack(snake_ack), .fruta_ack(fruta_ack), .obst_ack(obst_ack),
    .state_write(state_write), .state_xw(state_xw), .state_yw(state_yw),
    .state_wdata(state_wdata), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] clear_code(input int x, input int y);
`ifdef MAP_BORDER_WALL_EN
    if (x == 0 || x == 39 || y == 0 || y == 29) return 4'd3;
`endif
    return 4'd0;
  endfunction

  task automatic push_clear(input int count, input bit full);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.x    = 10'(i % 40);
      e.y    = 10'(i / 40);
      e.d    = clear_code(i % 40, i / 40);
      e.ack  = 3'b000;
      e.done = full && (i == 1199);
      q.push_back(e);
    end
  endtask

  task automatic push_grant(input int i);
    exp_t e;
    e.x    = rx[i];
    e.y    = ry[i];
    e.d    = rd[i];
    e.ack  = 3'(1 << i);
    e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input int x, input int y, input int d);
    rx[i]  = 10'(x);
    ry[i]  = 10'(y);
    rd[i]  = 4'(d);
    req[i] = 1'b1;
  endtask

  task automatic hold_until_ack(input int i, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (ackv[i]) seen = 1'b1;
    end
    req[i] = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout req=%0d got=0 want=1", i);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every write is popped against the scoreboard; idle cycles must be quiet
  always @(negedge clk) begin
    exp_t e, g;
    if (!reset) begin
      checks++;
      if (state_write) begin
        g = {state_xw, state_yw, state_wdata, ackv, clear_done};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got x=%0d y=%0d d=%0d ack=%b done=%b want=none",
                   state_xw, state_yw, state_wdata, ackv, clear_done);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL write got x=%0d y=%0d d=%0d ack=%b done=%b want x=%0d y=%0d d=%0d ack=%b done=%b",
                     state_xw, state_yw, state_wdata, ackv, clear_done, e.x, e.y, e.d, e.ack, e.done);
          end
        end
      end else if ({ackv, clear_done} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_strobe got ack=%b done=%b want 000/0", ackv, clear_done);
      end
    end
  end

  initial begin
    bit got_done;
    reset       = 1'b1;
    clear_start = 1'b0;
    req         = 3'b000;
    for (int i = 0; i < 3; i++) begin rx[i] = '0; ry[i] = '0; rd[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_write", 32'(state_write), 32'd0);
    check("rst_busy",  32'(busy),        32'd1);
    check("rst_ack",   32'(ackv),        32'd0);
    check("rst_done",  32'(clear_done),  32'd0);
    check("rst_addr",  {state_xw, state_yw, state_wdata}, 32'd0);

    // Sweep after reset, no requesters
    push_clear(1200, 1'b1);
    reset = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 1300 && !got_done; c++) begin
      @(negedge clk);
      if (clear_done) got_done = 1'b1;
    end
    check("sweep1_done_seen", 32'(got_done), 32'd1);
    check("sweep1_busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("post_clear_busy",  32'(busy),        32'd0);
    check("post_clear_write", 32'(state_write), 32'd0);

    // Single snake write, uncontested
    set_req(0, 5, 7, 2);
    push_grant(0);
    hold_until_ack(0, 1);

    // Obstacle with out-of-range coords passes through; pointer returns to snake
    set_req(2, 45, 31, 7);
    push_grant(2);
    hold_until_ack(2, 3);

    // All three held continuously: S F O S F O
    set_req(0, 1, 2, 1);
    set_req(1, 3, 4, 2);
    set_req(2, 6, 8, 3);
    repeat (2) begin push_grant(0); push_grant(1); push_grant(2); end
    repeat (6) @(posedge clk);
    #1 req = 3'b000;

    // Restart in ARB, then abort that sweep after 50 writes
    clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    check("restart_write", 32'(state_write), 32'd0);
    check("restart_busy",  32'(busy),        32'd1);
    push_clear(50, 1'b0);
    repeat (50) @(posedge clk);
    #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    check("abort_write", 32'(state_write), 32'd0);
    push_clear(1200, 1'b1);

    // Fruta requests at sweep cycle 100, served only after clear_done
    repeat (100) @(posedge clk);
    #1 set_req(1, 9, 9, 2);
    push_grant(1);
    hold_until_ack(1, 1300);
    check("fruta_after_sweep_busy", 32'(busy), 32'd0);

    // clear_start collides with an obstacle request in ARB
    set_req(2, 2, 3, 4);
    clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    check("collide_obst_ack", 32'(obst_ack),    32'd0);
    check("collide_write",    32'(state_write), 32'd0);
    push_clear(1200, 1'b1);
    push_grant(2);
    hold_until_ack(2, 1300);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Async reset in the middle of a sweep
    clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    push_clear(10, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_write", 32'(state_write), 32'd0);
    check("midreset_busy",  32'(busy),        32'd1);
    check("midreset_addr",  {state_xw, state_yw, state_wdata}, 32'd0);
    check("midreset_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
